bt_command_decoder: RTL
=======================

# bt_command_decoder

Parametrised command decoder for the Bluetooth remote-control path. It consumes bytes strobed out of the UART receiver and maintains the player's control state: track index, volume, mute and play/pause. It is event-driven, acting once per received byte. Compared with the fixed polled decoder it adds a configurable track count and volume range, step rate-limiting, a two-byte absolute-volume command, mute/play toggles and ack/error strobes. It sits between the UART receiver and the audio/track-select logic.

## Interface
- NUM_TRACKS, 5: number of selectable tracks; valid indices are 0..NUM_TRACKS-1.
- TRACK_W, 3: width of `current`; must satisfy 2^TRACK_W >= NUM_TRACKS.
- VOL_W, 16: volume width; must be a multiple of 8. Each byte lane is one channel.
- VOL_STEP, 16'h1010: increment/decrement amount for step commands.
- VOL_MAX, 16'hF0F0: upper clamp for the volume register.
- VOL_INIT, 16'h8080: volume register value at reset.
- HOLDOFF, 5_000_000: cycles during which further step commands are dropped after one is accepted.
- FRAME_TIMEOUT, 1_000_000: maximum cycles to wait for the value byte of a set-volume frame.

Ports:
- clk  in  1: system clock; all logic on its rising edge.
- rst  in  1: reset, asynchronous, active-low.
- rx_data  in  8: received byte, valid only when rx_valid=1.
- rx_valid  in  1: single-cycle strobe per received byte; back-to-back strobes allowed.
- volume  out  VOL_W: effective volume. Equals 0 while muted, otherwise the volume register.
- current  out  TRACK_W: selected track index.
- muted  out  1: mute state.
- playing  out  1: play (1) / pause (0) state.
- cmd_ack  out  1: one-cycle pulse when a command is applied.
- cmd_err  out  1: one-cycle pulse on an invalid byte or a frame timeout.

## Operation
- Reset values: volume register=VOL_INIT, current=0, muted=0, playing=0, cmd_ack=0, cmd_err=0, FSM=IDLE, holdoff counter=0, timeout counter=0.
- The FSM has two states, IDLE and WAIT_VOL. Commands decoded in IDLE:
  - 0x00..NUM_TRACKS-1: current=byte; ack.
  - Byte in 0x00..0xAF with value >= NUM_TRACKS: no state change; err.
  - 0xB1 (track previous): current-1; at 0 wraps to NUM_TRACKS-1.
  - 0xB2 (track next): current+1; at NUM_TRACKS-1 wraps to 0.
  - 0xB3 (volume down): vol = (vol < VOL_STEP) ? 0 : vol-VOL_STEP.
  - 0xB4 (volume up): vol = (vol > VOL_MAX-VOL_STEP) ? VOL_MAX : vol+VOL_STEP. Compute in VOL_W+1 bits; no overflow is allowed.
  - 0xB5: toggle muted. 0xB6: toggle playing. Both are applied unconditionally with ack.
  - 0xC0: go to WAIT_VOL; load timeout counter=FRAME_TIMEOUT; no ack yet.
  - Any other byte: err.
- Step commands (B1–B4):
  - A step command is accepted only when the holdoff counter is 0.
  - Acceptance applies the command, pulses ack and loads holdoff=HOLDOFF.
  - A step command arriving while holdoff != 0 is dropped silently: no ack, no err, counter not reloaded.
  - The counter decrements to 0 and holds there.
- Holdoff scope: holdoff never blocks absolute-select, B5, B6 or C0 commands. Those commands neither load nor clear the holdoff counter.
- WAIT_VOL:
  - The next rx_valid byte v is the value byte, whatever its code, including 0xB1..0xC0.
  - The volume register becomes v replicated into every byte lane, clamped to VOL_MAX if that replicated value exceeds VOL_MAX.
  - muted is unchanged. ack pulses; return to IDLE.
- Timeout: in WAIT_VOL the counter decrements each cycle without rx_valid. On reaching 0: err pulses, return to IDLE, volume unchanged.
- Mute interaction: step and set-volume commands modify the volume register while muted; output `volume` stays 0 until unmuted.

## Timing
- Latency: a byte strobed at edge N updates outputs at edge N+1. cmd_ack/cmd_err are asserted during the same cycle as the updated outputs.
- Throughput: one byte per cycle is sustained; each strobe is evaluated independently and no byte is lost.
- Simultaneous events:
  - rx_valid on the cycle the timeout counter would hit 0: the byte wins and is taken as the value byte; no err.
  - A step command on the cycle the holdoff counter is 1: dropped. A step command on the cycle the counter is 0: accepted.
- Reset asserted mid-frame: immediate asynchronous return to the reset values. A value byte arriving after release is decoded in IDLE.
- cmd_ack and cmd_err are never asserted together.

## Test plan
- Reset release, then 0x03 -> current=3, ack 1 cycle later. Then 0x07 -> current stays 3, err pulse.
- current=0, 0xB1 -> current=4. After HOLDOFF cycles, 0xB2 -> current=0. A 0xB2 sent 10 cycles after the first 0xB1 -> dropped, no ack, no err.
- VOL_INIT=0x8080, repeated 0xB4 spaced > HOLDOFF -> 0x9090 … 0xF0F0, then held. Repeated 0xB3 -> down to 0x0000, then held.
- 0xC0,0x40 back-to-back -> volume=0x4040, single ack. 0xC0,0xFF -> 0xF0F0 (clamped). 0xC0 then idle FRAME_TIMEOUT cycles -> err, volume unchanged; a following 0x40 byte -> current=0x40 rejected, err.
- 0xB5 -> muted=1, volume=0. 0xC0,0x20 -> volume output still 0. 0xB5 -> volume=0x2020. 0xB6 twice -> playing 1 then 0.
- Reset asserted while in WAIT_VOL -> all outputs at reset values immediately. After release, 0x02 -> current=2.

Source files
------------

// File: rtl/bt_command_decoder.sv
// Byte-driven remote-control decoder: track select, stepped/absolute volume,
// mute and play toggles, with step rate-limiting and a set-volume frame timeout.
module bt_command_decoder #(
   parameter int unsigned             NUM_TRACKS    = 5,
   parameter int unsigned             TRACK_W       = 3,
   parameter int unsigned             VOL_W         = 16,
   parameter logic [VOL_W-1:0]        VOL_STEP      = 16'h1010,
   parameter logic [VOL_W-1:0]        VOL_MAX       = 16'hF0F0,
   parameter logic [VOL_W-1:0]        VOL_INIT      = 16'h8080,
   parameter int unsigned             HOLDOFF       = 5_000_000,
   parameter int unsigned             FRAME_TIMEOUT = 1_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic [VOL_W-1:0]   volume,
   output logic [TRACK_W-1:0] current,
   output logic               muted,
   output logic               playing,
   output logic               cmd_ack,
   output logic               cmd_err
);

   localparam int unsigned HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
   localparam int unsigned TO_W = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT + 1) : 1;
   localparam logic [HO_W-1:0]    HO_LOAD  = HO_W'(HOLDOFF);
   localparam logic [TO_W-1:0]    TO_LOAD  = TO_W'(FRAME_TIMEOUT);
   localparam logic [7:0]         NT8      = 8'(NUM_TRACKS);
   localparam logic [TRACK_W-1:0] LAST_TRK = TRACK_W'(NUM_TRACKS - 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT_VOL
   } state_t;

   state_t             state_q, state_nxt;
   logic [VOL_W-1:0]   vol_q, vol_nxt;
   logic [TRACK_W-1:0] current_q, current_nxt;
   logic               muted_q, muted_nxt;
   logic               playing_q, playing_nxt;
   logic               ack_q, ack_nxt;
   logic               err_q, err_nxt;
   logic [HO_W-1:0]    ho_q, ho_nxt;
   logic [TO_W-1:0]    to_q, to_nxt;

   logic [VOL_W:0]     up_sum;
   logic [VOL_W-1:0]   vol_up, vol_dn, vol_set, vol_rep;

   // Sum kept one bit wider so the clamp also catches carry-out
   assign up_sum  = {1'b0, vol_q} + {1'b0, VOL_STEP};
   assign vol_up  = (up_sum > {1'b0, VOL_MAX}) ? VOL_MAX : up_sum[VOL_W-1:0];
   assign vol_dn  = (vol_q < VOL_STEP) ? '0 : (vol_q - VOL_STEP);
   assign vol_rep = {(VOL_W / 8){rx_data}};
   assign vol_set = (vol_rep > VOL_MAX) ? VOL_MAX : vol_rep;

   always_comb begin
      state_nxt   = state_q;
      vol_nxt     = vol_q;
      current_nxt = current_q;
      muted_nxt   = muted_q;
      playing_nxt = playing_q;
      ack_nxt     = 1'b0;
      err_nxt     = 1'b0;
      ho_nxt      = (ho_q == '0) ? '0 : (ho_q - HO_W'(1));
      to_nxt      = to_q;

      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_data < NT8) begin
                  current_nxt = rx_data[TRACK_W-1:0];
                  ack_nxt     = 1'b1;
               end else if (rx_data <= 8'hAF) begin
                  err_nxt = 1'b1;
               end else begin
                  case (rx_data)
                     8'hB1, 8'hB2, 8'hB3, 8'hB4: begin
                        // Steps inside the holdoff window vanish without a strobe
                        if (ho_q == '0) begin
                           ack_nxt = 1'b1;
                           ho_nxt  = HO_LOAD;
                           case (rx_data)
                              8'hB1:   current_nxt = (current_q == '0) ? LAST_TRK
                                                     : (current_q - TRACK_W'(1));
                              8'hB2:   current_nxt = (current_q == LAST_TRK) ? '0
                                                     : (current_q + TRACK_W'(1));
                              8'hB3:   vol_nxt = vol_dn;
                              default: vol_nxt = vol_up;
                           endcase
                        end
                     end
                     8'hB5: begin
                        muted_nxt = ~muted_q;
                        ack_nxt   = 1'b1;
                     end
                     8'hB6: begin
                        playing_nxt = ~playing_q;
                        ack_nxt     = 1'b1;
                     end
                     8'hC0: begin
                        state_nxt = S_WAIT_VOL;
                        to_nxt    = TO_LOAD;
                     end
                     default: err_nxt = 1'b1;
                  endcase
               end
            end
         end

         S_WAIT_VOL: begin
            // A byte on the expiring cycle still counts as the value byte
            if (rx_valid) begin
               vol_nxt   = vol_set;
               ack_nxt   = 1'b1;
               to_nxt    = '0;
               state_nxt = S_IDLE;
            end else if (to_q <= TO_W'(1)) begin
               err_nxt   = 1'b1;
               to_nxt    = '0;
               state_nxt = S_IDLE;
            end else begin
               to_nxt = to_q - TO_W'(1);
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         vol_q     <= VOL_INIT;
         current_q <= '0;
         muted_q   <= 1'b0;
         playing_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         ho_q      <= '0;
         to_q      <= '0;
      end else begin
         state_q   <= state_nxt;
         vol_q     <= vol_nxt;
         current_q <= current_nxt;
         muted_q   <= muted_nxt;
         playing_q <= playing_nxt;
         ack_q     <= ack_nxt;
         err_q     <= err_nxt;
         ho_q      <= ho_nxt;
         to_q      <= to_nxt;
      end
   end

   assign volume  = muted_q ? '0 : vol_q;
   assign current = current_q;
   assign muted   = muted_q;
   assign playing = playing_q;
   assign cmd_ack = ack_q;
   assign cmd_err = err_q;

endmodule
